// File: rtl/mpuf_challenge_gen_if.sv
// Challenge bus between the sequencer (master) and the capture side (slave).
// The capture side drives c_ready; the sequencer drives C, c_valid and chal_idx.
interface mpuf_challenge_gen_if #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned IDX_W = 16
);
  logic [WIDTH-1:0] C;
  logic             c_valid;
  logic             c_ready;
  logic [IDX_W-1:0] chal_idx;

  modport master (output C, output c_valid, output chal_idx, input c_ready);
  modport slave  (input C, input c_valid, input chal_idx, output c_ready);
endinterface

// File: rtl/mpuf_challenge_gen.sv
// LFSR challenge sequencer feeding the T1 transform stage.
// Each challenge is held for SETTLE cycles before it is offered over valid/ready.
module mpuf_challenge_gen #(
  parameter int unsigned     WIDTH  = 30,
  parameter logic [WIDTH-1:0] SEED  = 30'h1555_5555,
  parameter int unsigned     SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          num_chal,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  output logic                 busy,
  output logic                 done,
  mpuf_challenge_gen_if.master chal
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   num_q, num_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   lfsr_next;

  // Fibonacci LFSR, taps x^30 + x^6 + x^4 + x + 1
  assign lfsr_next = {c_q[WIDTH-2:0], c_q[WIDTH-1] ^ c_q[5] ^ c_q[3] ^ c_q[0]};

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      c_q     <= SEED;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed for the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    idx_d   = idx_q;
    c_d     = c_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // An all-zero state would lock the LFSR, so zero falls back to SEED.
        if (seed_load) begin
          c_d = (seed_in == '0) ? SEED : seed_in;
        end
        if (start) begin
          if (num_chal != '0) begin
            state_d = ST_SETTLE;
            num_d   = num_chal;
            idx_d   = '0;
            cnt_d   = SETTLE_INIT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_PRESENT;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_PRESENT: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (valid_q && chal.c_ready) begin
          valid_d = 1'b0;
          if (idx_q == num_q - IDX_W'(1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            c_d     = lfsr_next;
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = SETTLE_INIT;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign chal.C        = c_q;
  assign chal.c_valid  = valid_q;
  assign chal.chal_idx = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mpuf_challenge_gen.sv
// Self-checking bench for mpuf_challenge_gen against a sequence-level reference model.
module tb_mpuf_challenge_gen;

  localparam int unsigned   WIDTH  = 30;
  localparam int unsigned   SETTLE = 4;
  localparam logic [29:0]   SEED   = 30'h1555_5555;
  localparam logic [29:0]   TAPS   = 30'h2000_0029;

  logic        clk = 1'b0;
  logic        clear, start, abort, seed_load;
  logic [15:0] num_chal;
  logic [29:0] seed_in;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] model_c;

  mpuf_challenge_gen_if #(.WIDTH(WIDTH)) chal_if ();

  mpuf_challenge_gen #(.WIDTH(WIDTH), .SEED(SEED), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .abort     (abort),
    .num_chal  (num_chal),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy),
    .done      (done),
    .chal      (chal_if)
  );

  always #5 clk = ~clk;

  // Next challenge: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [29:0] ref_step(input logic [29:0] s);
    logic [29:0] shifted;
    shifted = s << 1;
    return shifted | 30'(^(s & TAPS));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int n, input bit do_load, input logic [29:0] load_val,
                        input int stall_idx, input int stall_len, input int abort_at);
    int          waited;
    logic [29:0] exp_c;
    if (do_load) begin
      seed_load = 1'b1;
      seed_in   = load_val;
      model_c   = (load_val == 30'h0) ? SEED : load_val;
    end
    num_chal = 16'(n);
    start    = 1'b1;
    chal_if.c_ready = 1'b0;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    exp_c     = model_c;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || chal_if.c_valid !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_flags busy=%b c_valid=%b done=%b expected 0 0 0", busy, chal_if.c_valid, done);
        end
        n_checks++;
        if (chal_if.chal_idx !== 16'(i)) begin
          n_fail++;
          $display("FAIL abort_idx got %0d expected %0d", chal_if.chal_idx, i);
        end
        n_checks++;
        if (chal_if.C !== exp_c) begin
          n_fail++;
          $display("FAIL abort_C got %h expected %h", chal_if.C, exp_c);
        end
        repeat (SETTLE + 2) begin
          tick();
          n_checks++;
          if (chal_if.c_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle c_valid=%b done=%b busy=%b expected 0 0 0", chal_if.c_valid, done, busy);
          end
        end
        model_c = exp_c;
        return;
      end
      waited = 0;
      while (chal_if.c_valid !== 1'b1 && waited < 64) begin
        chal_if.c_ready = 1'($urandom);
        start           = 1'($urandom);
        num_chal        = 16'($urandom);
        tick();
        waited++;
      end
      start = 1'b0;
      n_checks++;
      if (waited != SETTLE) begin
        n_fail++;
        $display("FAIL settle_time chal %0d waited %0d cycles expected %0d", i, waited, SETTLE);
        return;
      end
      n_checks++;
      if (chal_if.C !== exp_c || chal_if.chal_idx !== 16'(i)) begin
        n_fail++;
        $display("FAIL present chal %0d C=%h idx=%0d expected C=%h idx=%0d", i, chal_if.C, chal_if.chal_idx, exp_c, i);
      end
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL present_flags chal %0d busy=%b done=%b expected 1 0", i, busy, done);
      end
      if (i == stall_idx) begin
        chal_if.c_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          n_checks++;
          if (chal_if.c_valid !== 1'b1 || chal_if.C !== exp_c) begin
            n_fail++;
            $display("FAIL stall_hold c_valid=%b C=%h expected 1 %h", chal_if.c_valid, chal_if.C, exp_c);
          end
        end
      end
      chal_if.c_ready = 1'b1;
      tick();
      chal_if.c_ready = 1'b0;
      n_checks++;
      if (chal_if.c_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_drop chal %0d c_valid=%b expected 0", i, chal_if.c_valid);
      end
      if (i == n - 1) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || chal_if.C !== exp_c) begin
          n_fail++;
          $display("FAIL run_end done=%b busy=%b C=%h expected 1 0 %h", done, busy, chal_if.C, exp_c);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || chal_if.C !== exp_c) begin
          n_fail++;
          $display("FAIL done_pulse done=%b busy=%b C=%h expected 0 0 %h", done, busy, chal_if.C, exp_c);
        end
      end else begin
        exp_c = ref_step(exp_c);
      end
    end
    model_c = exp_c;
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
    num_chal = '0; seed_in = '0; chal_if.c_ready = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (chal_if.C !== SEED || chal_if.c_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || chal_if.chal_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL reset C=%h c_valid=%b busy=%b done=%b idx=%0d expected %h 0 0 0 0",
               chal_if.C, chal_if.c_valid, busy, done, chal_if.chal_idx, SEED);
    end
    clear = 1'b1;
    tick();
    model_c = SEED;
  endtask

  task automatic test_basic();
    do_run(4, 1'b1, 30'h1, -1, 0, -1);
    n_checks++;
    if (chal_if.C !== 30'hF) begin
      n_fail++;
      $display("FAIL basic_last_C got %h expected %h", chal_if.C, 30'hF);
    end
  endtask

  task automatic test_seed_load();
    seed_load = 1'b1; seed_in = 30'h0;
    tick();
    seed_load = 1'b0;
    model_c = SEED;
    n_checks++;
    if (chal_if.C !== SEED) begin
      n_fail++;
      $display("FAIL seed_zero got %h expected %h", chal_if.C, SEED);
    end
    num_chal = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    seed_load = 1'b1; seed_in = 30'($urandom) | 30'h1;
    tick();
    seed_load = 1'b0;
    n_checks++;
    if (chal_if.C !== model_c || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_busy C=%h busy=%b expected %h 1", chal_if.C, busy, model_c);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || chal_if.C !== model_c) begin
      n_fail++;
      $display("FAIL seed_busy_abort busy=%b C=%h expected 0 %h", busy, chal_if.C, model_c);
    end
  endtask

  task automatic test_stall();
    do_run(3, 1'b1, 30'h1, 1, 10, -1);
    n_checks++;
    if (chal_if.C !== 30'h7) begin
      n_fail++;
      $display("FAIL stall_last_C got %h expected %h", chal_if.C, 30'h7);
    end
  endtask

  task automatic test_zero();
    num_chal = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || chal_if.c_valid !== 1'b0 || chal_if.C !== model_c) begin
      n_fail++;
      $display("FAIL zero_run done=%b busy=%b c_valid=%b C=%h expected 1 0 0 %h",
               done, busy, chal_if.c_valid, chal_if.C, model_c);
    end
    abort = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b0 || chal_if.c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_end done=%b c_valid=%b expected 0 0", done, chal_if.c_valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle_start done=%b expected 1", done);
    end
    tick();
  endtask

  task automatic test_abort();
    do_run(5, 1'b1, 30'h1, -1, 0, 2);
    n_checks++;
    if (chal_if.C !== 30'h7) begin
      n_fail++;
      $display("FAIL abort_retained_C got %h expected %h", chal_if.C, 30'h7);
    end
    do_run(1, 1'b0, 30'h0, -1, 0, -1);
  endtask

  task automatic test_clear_mid();
    int waited;
    num_chal = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (chal_if.c_valid !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    n_checks++;
    if (chal_if.c_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pre_present c_valid=%b expected 1", chal_if.c_valid);
    end
    clear = 1'b0;
    #1;
    n_checks++;
    if (chal_if.C !== SEED || chal_if.c_valid !== 1'b0 || busy !== 1'b0 || chal_if.chal_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_async C=%h c_valid=%b busy=%b idx=%0d expected %h 0 0 0",
               chal_if.C, chal_if.c_valid, busy, chal_if.chal_idx, SEED);
    end
    tick();
    clear = 1'b1;
    model_c = SEED;
    tick();
    do_run(4, 1'b1, 30'h1, -1, 0, -1);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      int          n;
      bit          ld;
      logic [29:0] sv;
      n  = int'($urandom_range(1, 6));
      ld = 1'($urandom_range(0, 1));
      sv = ($urandom_range(0, 3) == 0) ? 30'h0 : 30'($urandom);
      do_run(n, ld, sv, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), -1);
      repeat (int'($urandom_range(0, 3))) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_load();
    test_stall();
    test_zero();
    test_abort();
    test_clear_mid();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
